// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead transmit byte FIFO with level, almost-full and sticky overflow status
module uart_tx_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_i,
  input  logic              tx_ready_i,
  input  logic              ovf_clr_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              push, pop;
  assign push          = wr_en_i && !full_o;
  assign pop           = tx_valid_o && tx_ready_i;
  assign full_o        = level == (ADDR_W+1)'(DEPTH);
  assign empty_o       = level == '0;
  assign almost_full_o = level >= (ADDR_W+1)'(AF_LEVEL);
  assign tx_valid_o    = !empty_o;
  assign tx_data_o     = mem[rd_ptr];
  assign level_o       = level;
  always_ff @(posedge pclk_i or negedge preset_n_i)
    if (!preset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow_o <= (wr_en_i && full_o) || (overflow_o && !ovf_clr_i);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_data_i;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        level <= level + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a reference model queues accepted bytes, a negedge monitor checks pops and status
module tb_uart_tx_fifo;
  logic       pclk_i = 0;
  logic       preset_n_i = 0;
  logic       wr_en_i = 0;
  logic [7:0] wr_data_i = 0;
  logic       flush_i = 0;
  logic       tx_ready_i = 0;
  logic       ovf_clr_i = 0;
  logic [7:0] tx_data_o;
  logic       tx_valid_o, full_o, empty_o, almost_full_o, overflow_o;
  logic [4:0] level_o;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         m_level = 0;
  logic       m_ovf = 0;

  uart_tx_fifo dut (
    .pclk_i(pclk_i), .preset_n_i(preset_n_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i), .tx_ready_i(tx_ready_i), .ovf_clr_i(ovf_clr_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepts by its own level, never by reading the DUT
  always @(posedge pclk_i or negedge preset_n_i)
    if (!preset_n_i) begin
      m_level <= 0;
      m_ovf   <= 0;
      exp_q.delete();
    end else begin
      m_ovf <= (wr_en_i && m_level == 16) || (m_ovf && !ovf_clr_i);
      if (flush_i) begin
        m_level <= 0;
        exp_q.delete();
      end else begin
        if (wr_en_i && m_level != 16) exp_q.push_back(wr_data_i);
        m_level <= m_level + int'(wr_en_i && m_level != 16) - int'(tx_ready_i && m_level != 0);
      end
    end

  always @(negedge pclk_i)
    if (preset_n_i) begin
      chk("level", level_o, m_level);
      chk("empty", empty_o, m_level == 0);
      chk("full", full_o, m_level == 16);
      chk("almost_full", almost_full_o, m_level >= 12);
      chk("valid", tx_valid_o, m_level != 0);
      chk("overflow", overflow_o, m_ovf);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) chk("pop_on_empty_model", 1, 0);
        else chk("data", tx_data_o, exp_q.pop_front());
      end
    end

  task automatic step();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    wr_en_i = 0; tx_ready_i = rdy;
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] d, input logic rdy);
    wr_en_i = 1; wr_data_i = d; tx_ready_i = rdy;
    step();
    wr_en_i = 0;
  endtask

  initial begin
    int b;
    repeat (3) step();
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_data", tx_data_o, 0);
    preset_n_i = 1;
    idle(2, 0);
    // Ordered fill and drain
    push(8'h93, 0);
    chk("valid_after_first_push", tx_valid_o, 1);
    chk("head_after_first_push", tx_data_o, 8'h93);
    push(8'h55, 0);
    push(8'hE1, 0);
    idle(5, 1);
    chk("empty_after_drain", empty_o, 1);
    // Full and overflow
    for (int i = 0; i <= 16; i++) push(8'(i), 0);
    chk("overflow_set", overflow_o, 1);
    chk("full_set", full_o, 1);
    idle(18, 1);
    ovf_clr_i = 1; step(); ovf_clr_i = 0;
    chk("overflow_cleared", overflow_o, 0);
    // Wrap-around with random stalls and concurrent push/pop
    b = 0;
    while (b < 40) begin
      wr_en_i = 1; wr_data_i = 8'(8'hA0 + b);
      tx_ready_i = ($urandom_range(0, 9) < 3);
      if (m_level != 16) b++;
      step();
    end
    idle(20, 1);
    chk("wrap_drained", exp_q.size(), 0);
    // Overflow set beats clear, then flush priority
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i), 0);
    wr_en_i = 1; wr_data_i = 8'hFF; ovf_clr_i = 1; step();
    wr_en_i = 0; ovf_clr_i = 0;
    chk("ovf_set_wins", overflow_o, 1);
    idle(9, 1);
    chk("level_7", level_o, 7);
    wr_en_i = 1; wr_data_i = 8'h77; tx_ready_i = 1; flush_i = 1; step();
    wr_en_i = 0; tx_ready_i = 0; flush_i = 0;
    chk("flush_level", level_o, 0);
    chk("flush_valid", tx_valid_o, 0);
    chk("flush_ovf_kept", overflow_o, 1);
    idle(2, 1);
    // Asynchronous reset with 5 entries queued
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 0);
    chk("level_5", level_o, 5);
    #2 preset_n_i = 0;
    #1;
    chk("async_rst_level", level_o, 0);
    chk("async_rst_empty", empty_o, 1);
    chk("async_rst_valid", tx_valid_o, 0);
    chk("async_rst_ovf", overflow_o, 0);
    chk("async_rst_data", tx_data_o, 0);
    step();
    preset_n_i = 1;
    push(8'h3C, 0);
    idle(3, 1);
    chk("final_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the APB register interface and the UART transmitter. It lets the MCU queue several THR writes back-to-back instead of polling TXEMPTY after every byte. APB writes to THR push bytes in. The transmitter pulls bytes out through a valid/ready handshake. Level, almost-full and sticky overflow status feed the UART status and interrupt logic.

## Interface
Parameters:
- DATA_W, 8, byte width.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).
- AF_LEVEL, 12, almost-full threshold; range 1..DEPTH.

Ports:
- pclk_i  in  1  single clock, rising edge.
- preset_n_i  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  push request; one-cycle pulse from an APB THR write.
- wr_data_i  in  DATA_W  byte to push.
- flush_i  in  1  synchronous clear of FIFO contents.
- tx_ready_i  in  1  transmitter can take a byte this cycle.
- ovf_clr_i  in  1  clears overflow_o.
- tx_data_o  out  DATA_W  head-of-FIFO byte (show-ahead).
- tx_valid_o  out  1  tx_data_o holds a valid byte.
- full_o  out  1  level equals DEPTH.
- empty_o  out  1  level equals 0.
- almost_full_o  out  1  level is at least AF_LEVEL.
- level_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky flag: a push was dropped.

## Operation
- Storage: DEPTH x DATA_W register array, plus wr_ptr and rd_ptr (ADDR_W bits each, wrap modulo DEPTH) and a level counter (ADDR_W+1 bits).
- Push accepted when wr_en_i=1 and full_o=0. Data is written at mem[wr_ptr], then wr_ptr increments.
- Pop occurs when tx_valid_o=1 and tx_ready_i=1, and then rd_ptr increments.
- tx_valid_o equals !empty_o.
- tx_data_o equals mem[rd_ptr], read combinationally from registered state. tx_data_o is meaningful only while tx_valid_o=1.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full with wr_en_i=1:
  - Push is dropped and memory is untouched.
  - overflow_o sets on the next edge.
  - This holds even if a pop happens in the same cycle; acceptance uses the registered full_o.
- Empty with tx_ready_i=1: no pop. Pointers and level stay unchanged; level never underflows.
- flush_i=1:
  - Next edge: wr_ptr=0, rd_ptr=0, level=0.
  - Overrides any push or pop in the same cycle.
  - Memory contents are not cleared.
  - overflow_o is unaffected.
- Overflow flag:
  - ovf_clr_i=1 clears overflow_o.
  - If a new dropped push occurs in the same cycle as ovf_clr_i, set wins and overflow_o stays 1.
- Flags full_o, empty_o and almost_full_o are decoded from the registered level. They are glitch-free and change only on clock edges.
- Pointer wrap: after mem[DEPTH-1], the next access is mem[0]. There is no skipped or extra entry.

## Timing
- Reset (preset_n_i=0, asynchronous assert, release synchronous to pclk_i):
  - Pointers, level and memory are 0.
  - tx_data_o=0, tx_valid_o=0, empty_o=1, full_o=0, almost_full_o=0, level_o=0, overflow_o=0.
- Push-to-valid latency: 1 cycle. A byte pushed into an empty FIFO at edge N appears on tx_data_o with tx_valid_o=1 after edge N.
- Pop-to-next-byte: tx_data_o shows the following entry after the popping edge. This allows one byte per cycle of sustained throughput.
- Status latency:
  - level_o and the flags reflect an operation 1 cycle after its edge.
  - overflow_o rises 1 cycle after the dropped push.
- Handshake: tx_valid_o never drops without a pop or flush. tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- Reset asserted mid-operation: everything returns immediately to the reset values, and any pending data is lost.

## Test plan
- Reset check:
  - Stimulus: assert preset_n_i=0 mid-simulation with 5 entries queued.
  - Required response: outputs go to the reset values without waiting for a clock edge; level_o=0, empty_o=1.
- Ordered fill and drain:
  - Stimulus: push 0x93, 0x55, 0xE1 with tx_ready_i=0, then hold tx_ready_i=1.
  - Required response: tx_valid_o=1 one cycle after the first push; pops return 0x93, 0x55, 0xE1 on consecutive cycles; empty_o=1 afterwards.
- Full and overflow:
  - Stimulus: push 17 bytes 0x00..0x10 with tx_ready_i=0.
  - Required response:
    - almost_full_o rises when level_o=12; full_o rises at level_o=16.
    - Byte 0x10 is dropped and overflow_o=1.
    - Drain returns exactly 0x00..0x0F.
  - Then pulse ovf_clr_i; overflow_o returns to 0.
- Wrap-around:
  - Stimulus: run 40 bytes through with random tx_ready_i stalls and simultaneous push and pop.
  - Required response: output sequence matches input order; level_o matches a scoreboard count every cycle.
- Flush and edge priority:
  - Stimulus: with level 7, assert flush_i together with wr_en_i and tx_ready_i.
  - Required response: next cycle level_o=0, tx_valid_o=0, overflow_o unchanged.
  - Follow-up stimulus: when full, assert ovf_clr_i in the same cycle as a dropped push.
  - Required response: overflow_o stays 1.
